// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read channel: one-cycle request pulse with a latched
// address, answered by a one-cycle valid strobe carrying the instruction word.
// The fetch unit drives the master side; memory drives the slave side.
interface instr_fetch_unit_if #(
  parameter int AW = 8,
  parameter int IW = 8
);
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_rdata;
  logic          imem_valid;

  modport master (output imem_req, imem_addr, input  imem_rdata, imem_valid);
  modport slave  (input  imem_req, imem_addr, output imem_rdata, imem_valid);
endinterface

// File: rtl/instr_fetch_unit.sv
// PC/IR fetch stage for the microcoded controller; FETCH_TIMEOUT_EN adds a WAIT watchdog.
// Latency: command sampled at N -> imem_req at N+1; valid at N+k -> IR/fetch_done at N+k+1.
// Backpressure: none; memory paces fetches via imem_valid, a held command fetches once.
module instr_fetch_unit #(
  parameter int            AW        = 8,
  parameter int            IW        = 8,
  parameter logic [AW-1:0] LAST_ADDR = '1,
  parameter int            TIMEOUT   = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [1:0]           mcontrol,
  input  logic                 pcd,
  input  logic                 pc_load,
  input  logic [AW-1:0]        pc_din,
  instr_fetch_unit_if.master   imem,
  output logic [3:0]           ir_out,
  output logic [IW-5:0]        ir_operand,
  output logic [AW-1:0]        pc,
  output logic                 fetch_done,
  output logic                 busy,
  output logic                 y,
  output logic                 fetch_err
);

  localparam logic [1:0] CMD_FETCH = 2'b01;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_HALT} state_t;

  state_t        state_q, state_d;
  logic          pcd_q;
  logic          inc;
  logic          req_d;
  logic [AW-1:0] addr_d;
  logic [3:0]    ir_d;
  logic [IW-5:0] opnd_d;
  logic          done_d;

  // Only the rising edge of pcd counts, so a held strobe advances once.
  assign inc = pcd & ~pcd_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pcd_q <= 1'b0;
      pc    <= '0;
      y     <= 1'b0;
    end else begin
      pcd_q <= pcd;
      if (pc_load) begin
        pc <= pc_din;
      end else if (inc) begin
        if (pc == LAST_ADDR) y  <= 1'b1;
        else                 pc <= pc + 1'b1;
      end
    end
  end

`ifdef FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_d;
`endif

  always_comb begin
    state_d = state_q;
    req_d   = 1'b0;
    addr_d  = imem.imem_addr;
    ir_d    = ir_out;
    opnd_d  = ir_operand;
    done_d  = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = fetch_err;
`endif
    case (state_q)
      S_IDLE: begin
        if (y) begin
          state_d = S_HALT;
        end else if (mcontrol == CMD_FETCH) begin
          addr_d  = pc;
          req_d   = 1'b1;
          state_d = S_REQ;
`ifdef FETCH_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      S_REQ, S_WAIT: begin
        if (imem.imem_valid) begin
          ir_d    = imem.imem_rdata[IW-1:IW-4];
          opnd_d  = imem.imem_rdata[IW-5:0];
          done_d  = 1'b1;
          state_d = S_DONE;
        end else if (state_q == S_REQ) begin
          state_d = S_WAIT;
`ifdef FETCH_TIMEOUT_EN
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          // Memory never answered: retire a NOP so the controller keeps moving.
          ir_d    = 4'b0000;
          opnd_d  = '0;
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
`endif
        end
      end
      S_DONE: begin
        if (mcontrol != CMD_FETCH) state_d = y ? S_HALT : S_IDLE;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      imem.imem_req  <= 1'b0;
      imem.imem_addr <= '0;
      ir_out         <= 4'b0000;
      ir_operand     <= '0;
      fetch_done     <= 1'b0;
    end else begin
      state_q        <= state_d;
      imem.imem_req  <= req_d;
      imem.imem_addr <= addr_d;
      ir_out         <= ir_d;
      ir_operand     <= opnd_d;
      fetch_done     <= done_d;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      fetch_err <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      fetch_err <= err_d;
    end
  end
`else
  assign fetch_err = 1'b0;
`endif

  assign busy = (state_q == S_REQ) || (state_q == S_WAIT);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed steps plus randomized PC/fetch traffic
// checked against a transaction-level model of the PC and instruction memory.
module tb_instr_fetch_unit;

  localparam logic [7:0] LAST = 8'h03;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] mcontrol = 2'b00;
  logic       pcd = 1'b0;
  logic       pc_load = 1'b0;
  logic [7:0] pc_din = 8'h00;
  logic [3:0] ir_out;
  logic [3:0] ir_operand;
  logic [7:0] pc;
  logic       fetch_done, busy, y, fetch_err;

  instr_fetch_unit_if #(.AW(8), .IW(8)) imem_bus ();

  instr_fetch_unit #(.AW(8), .IW(8), .LAST_ADDR(LAST), .TIMEOUT(16)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .mcontrol   (mcontrol),
    .pcd        (pcd),
    .pc_load    (pc_load),
    .pc_din     (pc_din),
    .imem       (imem_bus.master),
    .ir_out     (ir_out),
    .ir_operand (ir_operand),
    .pc         (pc),
    .fetch_done (fetch_done),
    .busy       (busy),
    .y          (y),
    .fetch_err  (fetch_err)
  );

  always #5 clock = ~clock;

  int n_pass = 0;
  int n_total = 0;

  logic [7:0] mem [256];
  logic [7:0] m_pc;
  logic       m_y;
  logic       m_prev;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One rising edge; the model applies the PC rules to the inputs seen at that edge.
  task automatic cyc();
    logic pcd_s, pl_s, inc;
    logic [7:0] din_s;
    pcd_s = pcd; pl_s = pc_load; din_s = pc_din;
    @(posedge clock); #1;
    if (reset_n) begin
      inc    = pcd_s && !m_prev;
      m_prev = pcd_s;
      if (pl_s) m_pc = din_s;
      else if (inc) begin
        if (m_pc == LAST) m_y = 1'b1;
        else              m_pc = m_pc + 8'd1;
      end
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0; mcontrol = 2'b00; pcd = 1'b0; pc_load = 1'b0; pc_din = 8'h00;
    imem_bus.imem_valid = 1'b0; imem_bus.imem_rdata = 8'h00;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_pc", pc, 0);           chk("rst_ir", ir_out, 0);
    chk("rst_opnd", ir_operand, 0); chk("rst_req", imem_bus.imem_req, 0);
    chk("rst_addr", imem_bus.imem_addr, 0);
    chk("rst_done", fetch_done, 0); chk("rst_busy", busy, 0);
    chk("rst_y", y, 0);             chk("rst_err", fetch_err, 0);
    reset_n = 1'b1;
    m_pc = 8'h00; m_y = 1'b0; m_prev = 1'b0;
  endtask

  task automatic rand_ctl();
    pcd     = 1'($urandom_range(0, 1));
    pc_load = ($urandom_range(0, 5) == 0);
    pc_din  = 8'($urandom_range(0, 7));
  endtask

  // One complete fetch with memory answering lat cycles after the request.
  task automatic fetch(input int lat, input bit rnd);
    logic [7:0] a;
    logic       exp_req;
    a = m_pc; exp_req = !m_y;
    mcontrol = 2'b01; pcd = 1'b0; pc_load = 1'b0;
    cyc();
    chk("f_req", imem_bus.imem_req, 16'(exp_req));
    if (exp_req) begin
      chk("f_addr", imem_bus.imem_addr, 16'(a));
      chk("f_busy_req", busy, 1);
      for (int i = 1; i < lat; i++) begin
        if (rnd) rand_ctl();
        cyc();
        chk("f_req_pulse", imem_bus.imem_req, 0);
        chk("f_no_early_done", fetch_done, 0);
        chk("f_busy_wait", busy, 1);
        chk("f_addr_stable", imem_bus.imem_addr, 16'(a));
      end
      if (rnd) rand_ctl();
      imem_bus.imem_valid = 1'b1; imem_bus.imem_rdata = mem[a];
      cyc();
      imem_bus.imem_valid = 1'b0; imem_bus.imem_rdata = 8'($urandom);
      chk("f_done", fetch_done, 1);
      chk("f_ir", ir_out, 16'(mem[a][7:4]));
      chk("f_opnd", ir_operand, 16'(mem[a][3:0]));
      chk("f_busy_after", busy, 0);
      chk("f_pc", pc, 16'(m_pc));
    end
    mcontrol = 2'b00; pcd = 1'b0; pc_load = 1'b0;
    cyc();
    chk("f_done_pulse", fetch_done, 0);
    chk("f_y", y, 16'(m_y));
    chk("f_pc_end", pc, 16'(m_pc));
  endtask

  initial begin
    int n_req, n_done;
    logic [3:0] ir_hold;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h4A; mem[1] = 8'h9E; mem[9] = 8'hC7;
    m_pc = 8'h00; m_y = 1'b0; m_prev = 1'b0;

    // Reset then fetch from address 0 with valid two cycles after the request.
    do_reset();
    fetch(2, 1'b0);
    chk("first_ir", ir_out, 16'h4);
    chk("first_opnd", ir_operand, 16'hA);

    // Held pcd advances once; pc_load beats a simultaneous pcd edge.
    pc_load = 1'b1; pc_din = 8'h05; cyc();
    pc_load = 1'b0; pcd = 1'b1;
    repeat (4) cyc();
    chk("held_pcd_pc", pc, 16'h06);
    pcd = 1'b0; cyc();
    pcd = 1'b1; pc_load = 1'b1; pc_din = 8'h20; cyc();
    chk("load_beats_inc", pc, 16'h20);
    pcd = 1'b0; pc_load = 1'b0; cyc();
    chk("load_pc_model", pc, 16'(m_pc));

    // Held command fetches exactly once.
    pc_load = 1'b1; pc_din = 8'h01; cyc(); pc_load = 1'b0;
    n_req = 0; n_done = 0; mcontrol = 2'b01;
    for (int i = 0; i < 10; i++) begin
      cyc();
      imem_bus.imem_valid = 1'b0;
      if (imem_bus.imem_req) n_req++;
      if (fetch_done) n_done++;
      if (i == 1) begin imem_bus.imem_valid = 1'b1; imem_bus.imem_rdata = mem[1]; end
    end
    mcontrol = 2'b00; cyc();
    chk("held_cmd_reqs", 16'(n_req), 1);
    chk("held_cmd_dones", 16'(n_done), 1);
    chk("held_cmd_ir", ir_out, 16'h9);

    // End of program: increment at LAST sets sticky y and blocks fetches.
    pc_load = 1'b1; pc_din = LAST; cyc(); pc_load = 1'b0;
    pcd = 1'b1; cyc(); pcd = 1'b0;
    chk("eop_y", y, 1);
    chk("eop_pc_hold", pc, 16'(LAST));
    ir_hold = ir_out; n_req = 0; mcontrol = 2'b01;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (imem_bus.imem_req || busy) n_req++;
    end
    chk("eop_no_req", 16'(n_req), 0);
    chk("eop_ir_hold", ir_out, 16'(ir_hold));
    mcontrol = 2'b00; pcd = 1'b1; cyc(); pcd = 1'b0; cyc();
    chk("eop_pc_still", pc, 16'(LAST));
    pc_load = 1'b1; pc_din = 8'h07; cyc(); pc_load = 1'b0;
    chk("eop_y_sticky", y, 1);
    chk("eop_pc_load", pc, 16'h07);
    do_reset();

    // Asynchronous reset while waiting; the late valid must be dropped.
    pc_load = 1'b1; pc_din = 8'h09; cyc(); pc_load = 1'b0;
    mcontrol = 2'b01; cyc();
    chk("mid_req", imem_bus.imem_req, 1);
    cyc();
    chk("mid_busy_wait", busy, 1);
    reset_n = 1'b0; mcontrol = 2'b00; #1;
    chk("mid_busy", busy, 0);  chk("mid_pc", pc, 0);
    chk("mid_ir", ir_out, 0);  chk("mid_req_clr", imem_bus.imem_req, 0);
    m_pc = 8'h00; m_y = 1'b0; m_prev = 1'b0;
    #2 reset_n = 1'b1;
    imem_bus.imem_valid = 1'b1; imem_bus.imem_rdata = mem[9];
    cyc();
    imem_bus.imem_valid = 1'b0;
    chk("late_done", fetch_done, 0);
    chk("late_ir", ir_out, 0);
    chk("late_opnd", ir_operand, 0);
    chk("late_busy", busy, 0);

    // Watchdog: with the feature a NOP retires after 16 WAIT cycles, otherwise WAIT persists.
    mcontrol = 2'b01; cyc(); mcontrol = 2'b00;
    chk("to_req", imem_bus.imem_req, 1);
`ifdef FETCH_TIMEOUT_EN
    n_done = 0;
    for (int i = 0; i < 16; i++) begin
      cyc();
      if (fetch_done) n_done++;
    end
    chk("to_no_early_done", 16'(n_done), 0);
    chk("to_busy_before", busy, 1);
    cyc();
    chk("to_done", fetch_done, 1);
    chk("to_ir_nop", ir_out, 0);
    chk("to_opnd", ir_operand, 0);
    chk("to_err", fetch_err, 1);
    cyc();
    chk("to_err_sticky", fetch_err, 1);
    chk("to_busy_after", busy, 0);
`else
    n_done = 0;
    for (int i = 0; i < 100; i++) begin
      cyc();
      if (fetch_done || !busy) n_done++;
    end
    chk("no_to_busy_held", 16'(n_done), 0);
    chk("no_to_err", fetch_err, 0);
`endif
    do_reset();

    // Randomized PC traffic and fetches against the model.
    for (int it = 0; it < 30; it++) begin
      int ncy;
      ncy = $urandom_range(1, 4);
      for (int c = 0; c < ncy; c++) begin
        rand_ctl();
        mcontrol = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b00;
        cyc();
        chk("rnd_pc", pc, 16'(m_pc));
        chk("rnd_y", y, 16'(m_y));
        chk("rnd_no_req", imem_bus.imem_req, 0);
      end
      pcd = 1'b0; pc_load = 1'b0; mcontrol = 2'b00;
      cyc();
      if (m_y) begin
        mcontrol = 2'b01; cyc(); mcontrol = 2'b00;
        chk("rnd_halt_no_req", imem_bus.imem_req, 0);
        do_reset();
      end else begin
        fetch($urandom_range(1, 5), 1'b1);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
